// File: rtl/dev_mgr_mon_pkg.sv
// Shared types and widths for the device manager status monitor.
// State encodings are visible to software through o_state.
package dev_mgr_mon_pkg;

  localparam int DM_STATUS_W = 32;
  localparam int CHG_CNT_W   = 16;
  localparam int PERST_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_READY   = 3'd2,
    ST_ERROR   = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

endpackage

// File: rtl/dev_mgr_sync2.sv
// Two-flop synchronizer with a selectable reset level.
// Used to bring asynchronous GPIO inputs into the i_clk domain.
module dev_mgr_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dev_mgr_status_monitor.sv
// Device manager start sequencing, status filtering and startup FSM.
// Holds sticky error/timeout flags, a status snapshot and diag counters.
module dev_mgr_status_monitor
  import dev_mgr_mon_pkg::*;
#(
  parameter int          LOCK_FILTER    = 16,
  parameter int          STABLE_CYCLES  = 32,
  parameter int          TIMEOUT_CYCLES = 50000000,
  parameter int          DONE_BIT       = 0,
  parameter logic [31:0] ERROR_MASK     = 32'hFFFF_0000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_pll_lock,
  input  logic [DM_STATUS_W-1:0] i_dm_status,
  input  logic                   i_pcie_perstn,
  input  logic                   i_clear,
  output logic                   o_dm_start,
  output logic                   o_ready,
  output logic                   o_error,
  output logic                   o_timeout,
  output logic [2:0]             o_state,
  output logic [DM_STATUS_W-1:0] o_status_snapshot,
  output logic [CHG_CNT_W-1:0]   o_change_count,
  output logic [PERST_CNT_W-1:0] o_perst_count
);

  localparam int LF_W  = $clog2(LOCK_FILTER + 1);
  localparam int ST_W  = $clog2(STABLE_CYCLES);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LF_W-1:0]  LF_LAST  = LF_W'(LOCK_FILTER - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t state;
  state_t state_n;

  logic [DM_STATUS_W-1:0] status_q;
  logic [DM_STATUS_W-1:0] accepted;
  logic [ST_W-1:0]        stable_cnt;
  logic [LF_W-1:0]        lock_cnt;
  logic [TMR_W-1:0]       timer;

  logic                   dm_start;
  logic                   err_flag;
  logic                   tmo_flag;
  logic [DM_STATUS_W-1:0] snapshot;
  logic [CHG_CNT_W-1:0]   chg_cnt;
  logic [PERST_CNT_W-1:0] perst_cnt;

  logic perst_sync;
  logic perst_prev;

  logic status_chg;
  logic acc_err;
  logic acc_done;
  logic perst_fall;
  logic enter_err;
  logic enter_tmo;
  logic err_base;
  logic tmo_base;
  logic capture;

  logic [CHG_CNT_W-1:0]   chg_base;
  logic [CHG_CNT_W-1:0]   chg_next;
  logic [PERST_CNT_W-1:0] perst_base;
  logic [PERST_CNT_W-1:0] perst_next;

  dev_mgr_sync2 #(
    .RESET_VAL (1'b1)
  ) u_perst_sync (
    .clk (i_clk),
    .rst (i_reset),
    .d   (i_pcie_perstn),
    .q   (perst_sync)
  );

  assign status_chg = (i_dm_status != status_q);
  assign acc_err    = |(accepted & ERROR_MASK);
  assign acc_done   = accepted[DONE_BIT];
  assign perst_fall = perst_prev & ~perst_sync;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (i_pll_lock && lock_cnt == LF_LAST)
          state_n = ST_START;
      end
      ST_START: begin
        if (!i_pll_lock)
          state_n = ST_IDLE;
        else if (acc_err)
          state_n = ST_ERROR;
        else if (acc_done)
          state_n = ST_READY;
        else if (timer == TMR_LAST)
          state_n = ST_TIMEOUT;
      end
      ST_READY: begin
        if (!i_pll_lock)
          state_n = ST_IDLE;
        else if (acc_err || !acc_done)
          state_n = ST_ERROR;
      end
      ST_ERROR, ST_TIMEOUT: begin
        if (!i_pll_lock || i_clear)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A clear lands first; an event in the same cycle re-applies on top.
  always_comb begin
    enter_err = (state != ST_ERROR) &&
                (state_n == ST_ERROR);
    enter_tmo = (state != ST_TIMEOUT) &&
                (state_n == ST_TIMEOUT);
    err_base  = i_clear ? 1'b0 : err_flag;
    tmo_base  = i_clear ? 1'b0 : tmo_flag;
    capture   = (enter_err || enter_tmo) &&
                !(err_base || tmo_base);

    chg_base = i_clear ? '0 : chg_cnt;
    chg_next = chg_base;
    if (status_chg && chg_base != '1)
      chg_next = chg_base + CHG_CNT_W'(1);

    perst_base = i_clear ? '0 : perst_cnt;
    perst_next = perst_base;
    if (perst_fall && perst_base != '1)
      perst_next = perst_base + PERST_CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      status_q   <= '0;
      accepted   <= '0;
      stable_cnt <= '0;
    end else begin
      status_q <= i_dm_status;
      if (status_chg)
        stable_cnt <= '0;
      else if (stable_cnt != ST_LAST)
        stable_cnt <= stable_cnt + ST_W'(1);
      if (stable_cnt == ST_LAST)
        accepted <= status_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      lock_cnt <= '0;
      timer    <= '0;
      dm_start <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && i_pll_lock &&
          lock_cnt != LF_LAST)
        lock_cnt <= lock_cnt + LF_W'(1);
      else
        lock_cnt <= '0;
      if (state == ST_START && state_n == ST_START)
        timer <= timer + TMR_W'(1);
      else
        timer <= '0;
      dm_start <= (state != ST_IDLE) &&
                  (state_n != ST_IDLE);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_flag   <= 1'b0;
      tmo_flag   <= 1'b0;
      snapshot   <= '0;
      chg_cnt    <= '0;
      perst_cnt  <= '0;
      perst_prev <= 1'b1;
    end else begin
      err_flag   <= err_base | enter_err;
      tmo_flag   <= tmo_base | enter_tmo;
      chg_cnt    <= chg_next;
      perst_cnt  <= perst_next;
      perst_prev <= perst_sync;
      if (capture)
        snapshot <= accepted;
      else if (i_clear)
        snapshot <= '0;
    end
  end

  assign o_dm_start        = dm_start;
  assign o_ready           = (state == ST_READY);
  assign o_error           = err_flag;
  assign o_timeout         = tmo_flag;
  assign o_state           = state;
  assign o_status_snapshot = snapshot;
  assign o_change_count    = chg_cnt;
  assign o_perst_count     = perst_cnt;

endmodule
